// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and encodings for the pipeline hazard / sequencing controller.
//   state_t          : controller state (FILL, RUN, FLUSH)
//   PC_SEQ/BR/JMP    : pc_sel encodings (PC+4, branch target, jump target)
//   BR_BEQ/BR_BNE    : EX_MEM_Branch encodings; 00 and 11 mean no branch
//   redirect_taken() : branch/jump resolution of the instruction in MEM
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'b00,
        RUN   = 2'b01,
        FLUSH = 2'b10
    } state_t;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    localparam logic [1:0] BR_BEQ = 2'b01;
    localparam logic [1:0] BR_BNE = 2'b10;

    function automatic logic redirect_taken(input logic [1:0] branch,
                                            input logic       zero,
                                            input logic       jump);
        return ((branch == BR_BEQ) &&  zero) ||
               ((branch == BR_BNE) && !zero) ||
               jump;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the pipeline datapath (master) and the hazard controller
// (slave).
//   hazard inputs : ID_rs, ID_rt, ID_uses_rt, ID_EX_MemtoReg, ID_EX_dst,
//                   EX_MEM_Branch, EX_MEM_zero, EX_MEM_Jump
//   controls      : pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush,
//                   EX_MEM_flush, pc_sel, fill_done
//   debug         : stall_count, flush_count (CNT_W bits, saturating)
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_rs;
    logic [4:0]       ID_rt;
    logic             ID_uses_rt;
    logic             ID_EX_MemtoReg;
    logic [4:0]       ID_EX_dst;
    logic [1:0]       EX_MEM_Branch;
    logic             EX_MEM_zero;
    logic             EX_MEM_Jump;

    logic             pc_write;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic             ID_EX_flush;
    logic             EX_MEM_flush;
    logic [1:0]       pc_sel;
    logic             fill_done;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output ID_rs, ID_rt, ID_uses_rt, ID_EX_MemtoReg, ID_EX_dst,
               EX_MEM_Branch, EX_MEM_zero, EX_MEM_Jump,
        input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush,
               pc_sel, fill_done, stall_count, flush_count
    );

    modport slave (
        input  ID_rs, ID_rt, ID_uses_rt, ID_EX_MemtoReg, ID_EX_dst,
               EX_MEM_Branch, EX_MEM_zero, EX_MEM_Jump,
        output pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush,
               pc_sel, fill_done, stall_count, flush_count
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clock : counting clock
//   reset : asynchronous active-high clear
//   inc   : count one event at this edge
//   q     : current count (W bits)
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else if (inc && (q_q != '1)) begin
            q_q <= q_q + 1'b1;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Sequencing controller for the IF/ID, ID/EX, EX/MEM and MEM/WB registers:
// masks redirects while the pipeline fills after reset, inserts load-use
// bubbles, flushes wrong-path instructions when a branch/jump resolves in
// MEM, selects the next-PC source and keeps saturating stall/flush counters.
//   clock : pipeline clock
//   reset : asynchronous active-high; forces FILL and clears counters
//   bus   : pipeline_hazard_ctrl_if.slave (hazard inputs, controls, counters)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   FILL  | pipeline filling after reset; redirects masked, pc_sel=PC+4
//   RUN   | normal operation; redirect has priority over load-use stall
//   FLUSH | bubbles in ID/EX after a redirect; all hazards ignored
// ---------------------------------------------------------------------------
import pipe_ctrl_pkg::*;

module pipeline_hazard_ctrl #(
    parameter int FILL_CYCLES = 3,
    parameter int CNT_W       = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int              FC_W      = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
    localparam logic [FC_W-1:0] FILL_LAST = FC_W'(FILL_CYCLES - 1);

    state_t          state_q, state_d;
    logic [FC_W-1:0] fill_cnt_q, fill_cnt_d;

    logic            in_run;
    logic            loaduse_window;
    logic            taken;
    logic            loaduse;
    logic            stall_evt;
    logic            flush_evt;

    logic            pc_write;
    logic            if_id_write;
    logic            if_id_flush;
    logic            id_ex_flush;
    logic            ex_mem_flush;
    logic [1:0]      pc_sel;

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // EX_MEM inputs may be X during FILL; the select form keeps them out
    // of every downstream term instead of relying on AND masking.
    assign in_run = (state_q == RUN);
    assign taken  = in_run ? redirect_taken(bus.EX_MEM_Branch, bus.EX_MEM_zero,
                                            bus.EX_MEM_Jump)
                           : 1'b0;

    // Load-use is legal in RUN and in the last fill cycle, when ID/EX is
    // already holding a real instruction.
    assign loaduse_window = !reset &&
                            (in_run || ((state_q == FILL) && (fill_cnt_q >= FILL_LAST)));

    assign loaduse = loaduse_window ?
                     (bus.ID_EX_MemtoReg && (bus.ID_EX_dst != 5'd0) &&
                      ((bus.ID_EX_dst == bus.ID_rs) ||
                       (bus.ID_uses_rt && (bus.ID_EX_dst == bus.ID_rt))))
                     : 1'b0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_sel       = PC_SEQ;
        stall_evt    = 1'b0;
        flush_evt    = 1'b0;

        case (state_q)
            FILL: begin
                if (fill_cnt_q == FILL_LAST) begin
                    state_d = RUN;
                end else begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                end
                if (loaduse) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    stall_evt   = 1'b1;
                end
            end

            RUN: begin
                if (taken) begin
                    pc_sel       = bus.EX_MEM_Jump ? PC_JMP : PC_BR;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    flush_evt    = 1'b1;
                    state_d      = FLUSH;
                end else if (loaduse) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    stall_evt   = 1'b1;
                end
            end

            FLUSH: begin
                state_d = RUN;
            end

            default: begin
                state_d    = FILL;
                fill_cnt_d = '0;
            end
        endcase
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (stall_evt),
        .q     (stall_q)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (flush_evt),
        .q     (flush_q)
    );

    assign bus.pc_write     = pc_write;
    assign bus.IF_ID_write  = if_id_write;
    assign bus.IF_ID_flush  = if_id_flush;
    assign bus.ID_EX_flush  = id_ex_flush;
    assign bus.EX_MEM_flush = ex_mem_flush;
    assign bus.pc_sel       = pc_sel;
    assign bus.fill_done    = (state_q != FILL);
    assign bus.stall_count  = stall_q;
    assign bus.flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed table of per-cycle vectors with hand-computed expectations for
// the default controller, followed by hand-written sequences for reset in
// FLUSH and counter saturation on a CNT_W=4 instance.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    logic clock;
    logic reset;

    int n_cmp = 0;
    int n_err = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) hif ();
    pipeline_hazard_ctrl_if #(.CNT_W(4))  hif4 ();

    pipeline_hazard_ctrl #(.FILL_CYCLES(3), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (hif)
    );

    pipeline_hazard_ctrl #(.FILL_CYCLES(3), .CNT_W(4)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (hif4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       m2r;
        logic [4:0] dst;
        logic [1:0] br;
        logic       zero;
        logic       jmp;
        logic [6:0] e_ctrl;   // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush, pc_sel}
        logic       e_fd;
        int         e_stall;
        int         e_flush;
    } vec_t;

    localparam logic [6:0] C_DEF   = 7'b11_000_00;
    localparam logic [6:0] C_STALL = 7'b00_010_00;
    localparam logic [6:0] C_BR    = 7'b11_111_01;
    localparam logic [6:0] C_JMP   = 7'b11_111_10;

    vec_t vecs[19];

    function automatic vec_t mk(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                                input logic uses_rt, input logic m2r, input logic [4:0] dst,
                                input logic [1:0] br, input logic zero, input logic jmp,
                                input logic [6:0] ctrl, input logic fd, input int s, input int f);
        vec_t v;
        v.name = nm; v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.m2r = m2r; v.dst = dst;
        v.br = br; v.zero = zero; v.jmp = jmp; v.e_ctrl = ctrl; v.e_fd = fd;
        v.e_stall = s; v.e_flush = f;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        hif.ID_rs          = v.rs;
        hif.ID_rt          = v.rt;
        hif.ID_uses_rt     = v.uses_rt;
        hif.ID_EX_MemtoReg = v.m2r;
        hif.ID_EX_dst      = v.dst;
        hif.EX_MEM_Branch  = v.br;
        hif.EX_MEM_zero    = v.zero;
        hif.EX_MEM_Jump    = v.jmp;
    endtask

    function automatic logic [6:0] ctrl_main();
        return {hif.pc_write, hif.IF_ID_write, hif.IF_ID_flush, hif.ID_EX_flush,
                hif.EX_MEM_flush, hif.pc_sel};
    endfunction

    initial begin
        vec_t idle;
        //               name         rs  rt  ur m2r dst br     z  j   ctrl     fd s  f
        vecs[0]  = mk("fill_beq0",    0,  0,  0, 0,  0, 2'b01, 1, 0, C_DEF,   0, 0, 0);
        vecs[1]  = mk("fill_beq1_lu", 8,  0,  0, 1,  8, 2'b01, 1, 0, C_DEF,   0, 0, 0);
        vecs[2]  = mk("fill_last_lu", 1,  5,  1, 1,  5, 2'b00, 0, 0, C_STALL, 0, 0, 0);
        vecs[3]  = mk("run_lu_rs",    8,  0,  0, 1,  8, 2'b00, 0, 0, C_STALL, 1, 1, 0);
        vecs[4]  = mk("run_lu_r0",    0,  0,  1, 1,  0, 2'b00, 0, 0, C_DEF,   1, 2, 0);
        vecs[5]  = mk("run_rt_unused",3,  7,  0, 1,  7, 2'b00, 0, 0, C_DEF,   1, 2, 0);
        vecs[6]  = mk("run_beq",      0,  0,  0, 0,  0, 2'b01, 1, 0, C_BR,    1, 2, 0);
        vecs[7]  = mk("flush_ignore", 8,  0,  0, 1,  8, 2'b01, 1, 0, C_DEF,   1, 2, 1);
        vecs[8]  = mk("run_bne_z1",   0,  0,  0, 0,  0, 2'b10, 1, 0, C_DEF,   1, 2, 1);
        vecs[9]  = mk("run_bne_z0",   0,  0,  0, 0,  0, 2'b10, 0, 0, C_BR,    1, 2, 1);
        vecs[10] = mk("flush_idle",   0,  0,  0, 0,  0, 2'b00, 0, 0, C_DEF,   1, 2, 2);
        vecs[11] = mk("run_jmp_lu",   8,  0,  0, 1,  8, 2'b00, 0, 1, C_JMP,   1, 2, 2);
        vecs[12] = mk("flush_lu_ign", 8,  0,  0, 1,  8, 2'b00, 0, 0, C_DEF,   1, 2, 3);
        vecs[13] = mk("lu_after_fl",  8,  0,  0, 1,  8, 2'b00, 0, 0, C_STALL, 1, 2, 3);
        vecs[14] = mk("run_idle",     0,  0,  0, 0,  0, 2'b00, 0, 0, C_DEF,   1, 3, 3);
        vecs[15] = mk("run_br11",     0,  0,  0, 0,  0, 2'b11, 1, 0, C_DEF,   1, 3, 3);
        vecs[16] = mk("run_noload",   8,  0,  0, 0,  8, 2'b00, 0, 0, C_DEF,   1, 3, 3);
        vecs[17] = mk("run_beq_z0",   0,  0,  0, 0,  0, 2'b01, 0, 0, C_DEF,   1, 3, 3);
        vecs[18] = mk("run_beq_last", 0,  0,  0, 0,  0, 2'b01, 1, 0, C_BR,    1, 3, 3);

        idle = mk("idle", 0, 0, 0, 0, 0, 2'b00, 0, 0, C_DEF, 0, 0, 0);

        hif4.ID_rs = '0; hif4.ID_rt = '0; hif4.ID_uses_rt = 1'b0; hif4.ID_EX_MemtoReg = 1'b0;
        hif4.ID_EX_dst = '0; hif4.EX_MEM_Branch = '0; hif4.EX_MEM_zero = 1'b0;
        hif4.EX_MEM_Jump = 1'b0;

        // Reset values
        reset = 1'b1;
        drive(idle);
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_ctrl", 32'(ctrl_main()), 32'(C_DEF));
        chk("reset_fill_done", 32'(hif.fill_done), 32'd0);
        chk("reset_stall_cnt", 32'(hif.stall_count), 32'd0);
        chk("reset_flush_cnt", 32'(hif.flush_count), 32'd0);
        reset = 1'b0;

        // Table: one vector per cycle, checked before the closing edge
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("%s[%0d] ctrl", vecs[i].name, i), 32'(ctrl_main()), 32'(vecs[i].e_ctrl));
            chk($sformatf("%s[%0d] fill_done", vecs[i].name, i), 32'(hif.fill_done), 32'(vecs[i].e_fd));
            chk($sformatf("%s[%0d] stall_cnt", vecs[i].name, i), 32'(hif.stall_count), 32'(vecs[i].e_stall));
            chk($sformatf("%s[%0d] flush_cnt", vecs[i].name, i), 32'(hif.flush_count), 32'(vecs[i].e_flush));
            @(negedge clock);
        end

        // Now in FLUSH after the last redirect; reset must abort it at once
        drive(mk("taken", 0, 0, 0, 0, 0, 2'b01, 1, 0, C_DEF, 0, 0, 0));
        #1;
        chk("pre_reset_flush_cnt", 32'(hif.flush_count), 32'd4);
        reset = 1'b1;
        #1;
        chk("rst_in_flush_ctrl", 32'(ctrl_main()), 32'(C_DEF));
        chk("rst_in_flush_fill_done", 32'(hif.fill_done), 32'd0);
        chk("rst_in_flush_stall_cnt", 32'(hif.stall_count), 32'd0);
        chk("rst_in_flush_flush_cnt", 32'(hif.flush_count), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("post_rst_c0_ctrl", 32'(ctrl_main()), 32'(C_DEF));
        @(negedge clock);
        chk("post_rst_c1_ctrl", 32'(ctrl_main()), 32'(C_DEF));
        chk("post_rst_c1_fill_done", 32'(hif.fill_done), 32'd0);
        drive(idle);
        @(negedge clock);
        chk("post_rst_c2_fill_done", 32'(hif.fill_done), 32'd0);
        @(negedge clock);
        chk("post_rst_c3_fill_done", 32'(hif.fill_done), 32'd1);
        chk("post_rst_flush_cnt", 32'(hif.flush_count), 32'd0);

        // Saturation on the CNT_W=4 instance (already in RUN)
        chk("sat_fill_done", 32'(hif4.fill_done), 32'd1);
        hif4.ID_EX_MemtoReg = 1'b1;
        hif4.ID_EX_dst      = 5'd8;
        hif4.ID_rs          = 5'd8;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk($sformatf("sat_stall_cnt[%0d]", i), 32'(hif4.stall_count), 32'((i < 15) ? i : 15));
            @(negedge clock);
        end
        chk("sat_stall_final", 32'(hif4.stall_count), 32'd15);
        chk("sat_still_stalling", 32'(hif4.pc_write), 32'd0);
        hif4.ID_EX_MemtoReg = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequencing controller for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It masks branch/jump resolution while the pipeline fills after reset, inserts one-cycle load-use bubbles, flushes wrong-path instructions when a branch or jump resolves in MEM, and selects the next-PC source. It also keeps saturating stall and flush counters for performance debug.

## Interface
- FILL_CYCLES, 3: cycles after reset before EX/MEM contents are valid; redirect is masked until then.
- CNT_W, 16: width of the performance counters.
- clock  in  1  pipeline clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; forces FILL state and clears all counters.
- ID_rs  in  5  rs field of the instruction in ID.
- ID_rt  in  5  rt field of the instruction in ID.
- ID_uses_rt  in  1  ID instruction reads rt as a source.
- ID_EX_MemtoReg  in  1  instruction in EX is a load.
- ID_EX_dst  in  5  destination register of the instruction in EX.
- EX_MEM_Branch  in  2  01 = beq, 10 = bne, 00/11 = no branch.
- EX_MEM_zero  in  1  ALU zero flag of the instruction in MEM.
- EX_MEM_Jump  in  1  instruction in MEM is a jump.
- pc_write  out  1  PC load enable.
- IF_ID_write  out  1  IF/ID load enable.
- IF_ID_flush, ID_EX_flush, EX_MEM_flush  out  1 each  load bubble (all controls 0) at the next edge.
- pc_sel  out  2  00 = PC+4, 01 = branch target, 10 = jump target.
- fill_done  out  1  high once state has left FILL.
- stall_count, flush_count  out  CNT_W  saturating event counters.

## Operation
- States: FILL, RUN, FLUSH. A fill counter fill_cnt runs 0..FILL_CYCLES-1.
- taken = (Branch==01 & zero) | (Branch==10 & ~zero) | Jump.
- loaduse = ID_EX_MemtoReg & ID_EX_dst!=0 & (ID_EX_dst==ID_rs | (ID_uses_rt & ID_EX_dst==ID_rt)).
- FILL: taken is ignored and pc_sel=00. loaduse is honoured only when fill_cnt>=FILL_CYCLES-1. fill_cnt increments each cycle. At fill_cnt==FILL_CYCLES-1, the next state is RUN.
- RUN with taken:
  - pc_sel = Jump ? 10 : 01.
  - IF_ID_flush, ID_EX_flush and EX_MEM_flush all asserted.
  - pc_write=1.
  - flush_count+1.
  - Next state FLUSH.
  - Redirect has priority over loaduse; loaduse is not counted in that cycle.
- RUN with loaduse and not taken:
  - pc_write=0, IF_ID_write=0, ID_EX_flush=1.
  - stall_count+1.
  - Stay in RUN.
- FLUSH: taken and loaduse are both ignored, since the ID and EX stages hold bubbles. Outputs are at their defaults. Next state RUN.
- Defaults when no event applies: pc_write=1, IF_ID_write=1, all flushes 0, pc_sel=00.
- Counters saturate at all-ones and never wrap.

## Timing
- Flush, stall and pc_sel outputs are combinational from the registered state and the current inputs. They take effect at the same posedge (zero latency).
- State, fill_cnt and the counters are registered. A counter increments at the edge that ends the event cycle.
- Reset values (asynchronous, immediate):
  - state=FILL, fill_cnt=0, fill_done=0.
  - pc_write=1, IF_ID_write=1.
  - All flushes 0, pc_sel=00.
  - stall_count=0, flush_count=0.
- Reset asserted mid-FLUSH or mid-stall aborts the operation immediately. No pending redirect survives.
- X or undefined EX_MEM inputs during FILL must not propagate to the outputs; mask them explicitly.
- A loaduse immediately following FLUSH in RUN is honoured normally.

## Structure
- Package pipe_ctrl_pkg holds:
  - state enum {FILL, RUN, FLUSH};
  - PC_SEQ/PC_BR/PC_JMP pc_sel constants;
  - BR_BEQ/BR_BNE encodings.
- Sub-module sat_counter (parameter W; inputs clock, reset, inc; output q) is instantiated twice.

## Test plan
- Reset, then idle inputs with EX_MEM_Branch=01, zero=1 during the first 2 cycles → no redirect, pc_sel=00. fill_done rises after cycle 3.
- RUN: ID_EX_MemtoReg=1, ID_EX_dst=8, ID_rs=8 → pc_write=0, IF_ID_write=0, ID_EX_flush=1 for 1 cycle; stall_count=1. Repeat with ID_EX_dst=0 → no stall.
- RUN: Branch=01, zero=1 → pc_sel=01 and all three flushes for 1 cycle, then FLUSH, then RUN; flush_count=1. Branch=10, zero=1 → no action.
- RUN: Jump=1 together with a matching loaduse → pc_sel=10, flushes asserted, pc_write=1; stall_count unchanged. The loaduse presented in the following FLUSH cycle is ignored.
- Assert reset in the FLUSH cycle → state FILL, counters 0, all outputs at reset values the same cycle.
- CNT_W=4, 20 load-use stalls → stall_count holds at 15.
